// File: rtl/spi_slave_hs_if.sv
// Serial link and status bundle between an SPI master and the spi_slave_hs responder.
interface spi_slave_hs_if;
  logic        CS_b;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] last_cmd_A;
  logic [15:0] last_cmd_B;
  logic [9:0]  frame_cnt;

  modport master (
    output CS_b, SCLK, MOSI,
    input  MISO, frame_done, frame_err, last_cmd_A, last_cmd_B, frame_cnt
  );

  modport slave (
    input  CS_b, SCLK, MOSI,
    output MISO, frame_done, frame_err, last_cmd_A, last_cmd_B, frame_cnt
  );
endinterface

// File: rtl/spi_slave_hs.sv
// Oversampled SPI responder emulating a two-channel acquisition front end.
// Define SPI_SLAVE_PIPE2_EN for 2-frame response latency; default is 1-frame latency.
module spi_slave_hs #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] IDLE_RESP   = 16'h0000
) (
  input logic         CLK,
  input logic         RST_b,
  spi_slave_hs_if.slave bus
);

`ifdef SPI_SLAVE_PIPE2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  // Top bit of the CS_b/SCLK chains is the history flop used for edge detection.
  logic [SYNC_STAGES:0]   cs_sync_q;
  logic [SYNC_STAGES:0]   sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  logic [5:0]  bit_cnt_q,    bit_cnt_d;
  logic [31:0] shift_in_q,   shift_in_d;
  logic [31:0] shift_out_q,  shift_out_d;
  logic        miso_q,       miso_d;
  logic        done_q,       done_d;
  logic        err_q,        err_d;
  logic [15:0] cmd_a_q,      cmd_a_d;
  logic [15:0] cmd_b_q,      cmd_b_d;
  logic [9:0]  frame_cnt_q,  frame_cnt_d;
  logic [31:0] fifo_q [DEPTH];
  logic [31:0] fifo_d [DEPTH];

  logic cs_s, cs_h, sclk_s, sclk_h, mosi_s;
  logic cs_fall, cs_rise, sclk_rise;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign cs_h      = cs_sync_q[SYNC_STAGES];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sclk_h    = sclk_sync_q[SYNC_STAGES];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_h & ~cs_s;
  assign cs_rise   = ~cs_h & cs_s;
  // Gating on the history level lets a rise coincident with CS_b rise still count.
  assign sclk_rise = sclk_s & ~sclk_h & ~cs_h;

  function automatic logic [15:0] decode(input logic [15:0] c, input logic [5:0] cnt,
                                         input logic half_b);
    logic [9:0] sample;
    sample = {c[11:8], cnt};
    if (c[15:14] == 2'b00)
      decode = half_b ? {6'b0, ~sample} : {6'b0, sample};
    else
      decode = 16'hFF00 | {10'b0, c[13:8]};
  endfunction

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cmd_a_d     = cmd_a_q;
    cmd_b_d     = cmd_b_q;
    frame_cnt_d = frame_cnt_q;
    fifo_d      = fifo_q;
    miso_d      = cs_s ? 1'b0 : shift_out_q[31];

    if (cs_fall) begin
      bit_cnt_d   = 6'd0;
      shift_out_d = fifo_q[0];
    end

    if (sclk_rise) begin
      shift_in_d  = {shift_in_q[30:0], mosi_s};
      bit_cnt_d   = (bit_cnt_q == 6'd63) ? 6'd63 : bit_cnt_q + 6'd1;
      shift_out_d = {shift_out_q[30:0], 1'b0};
    end

    if (cs_rise) begin
      if (bit_cnt_d == 6'd32) begin
        cmd_a_d     = shift_in_d[31:16];
        cmd_b_d     = shift_in_d[15:0];
        frame_cnt_d = frame_cnt_q + 10'd1;
        done_d      = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++)
          fifo_d[i] = fifo_q[i+1];
        fifo_d[DEPTH-1] = {decode(shift_in_d[31:16], frame_cnt_q[5:0], 1'b0),
                           decode(shift_in_d[15:0],  frame_cnt_q[5:0], 1'b1)};
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_b) begin
    if (!RST_b) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      miso_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_a_q     <= '0;
      cmd_b_q     <= '0;
      frame_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        fifo_q[i] <= {IDLE_RESP, IDLE_RESP};
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-1:0], bus.CS_b};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], bus.SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_a_q     <= cmd_a_d;
      cmd_b_q     <= cmd_b_d;
      frame_cnt_q <= frame_cnt_d;
      fifo_q      <= fifo_d;
    end
  end

  assign bus.MISO       = miso_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.last_cmd_A = cmd_a_q;
  assign bus.last_cmd_B = cmd_b_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule
